logic_unit_driver: RTL and testbench

Initiator-side companion to the ALU's combinational AND/XOR logic unit. It accepts logic-operation commands over a valid/ready handshake, registers the operands onto the logic unit's input ports, and captures the unit's result one cycle later. It then returns results in order over a valid/ready result channel backed by a 2-entry buffer. It sits between the execute-stage issue logic and the ALU logic unit, and sustains one operation per cycle when the result consumer is not stalling.

---
 rtl/logic_unit_driver.sv | 202 ++++++++++++++++++++
 tb/tb_logic_unit_driver.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_driver.sv
//------------------------------------------------------------------------------
// logic_unit_driver
//
// Initiator-side companion to the ALU's combinational AND/XOR logic unit.
// Commands arrive over a valid/ready handshake and are registered onto the
// logic unit's operand ports (stage 1). One cycle later the unit's result is
// captured, together with a zero flag, into a 2-entry in-order result buffer
// (stage 2). Results leave over a valid/ready result channel. With the result
// consumer not stalling, one operation per cycle is sustained.
//
// Parameters
//   WIDTH      operand / result width
//   CNT_W      width of the completed-operation (pop) counter
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  command accepted when cmd_valid && cmd_ready at a clk edge
//   cmd_a      operand a
//   cmd_b      operand b
//   cmd_fn     function select, 1 = XOR, 0 = AND (passed through untouched)
//   lu_a       registered operand a to the logic unit
//   lu_b       registered operand b to the logic unit
//   lu_fn      registered function select to the logic unit
//   lu_c       combinational result from the logic unit
//   res_valid  result buffer non-empty
//   res_ready  consumer takes the head result when res_valid && res_ready
//   res_data   head result
//   res_zero   head result == 0
//   busy       stage 1 occupied or result buffer non-empty
//   ops_count  results popped since reset, wrapping
//------------------------------------------------------------------------------
module logic_unit_driver #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic             cmd_fn,
   output logic [WIDTH-1:0] lu_a,
   output logic [WIDTH-1:0] lu_b,
   output logic             lu_fn,
   input  logic [WIDTH-1:0] lu_c,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_zero,
   output logic             busy,
   output logic [CNT_W-1:0] ops_count
);

   // Zero detect for a captured result word.
   function automatic logic is_zero(input logic [WIDTH-1:0] value);
      return (value == {WIDTH{1'b0}});
   endfunction

   // Stage 1: operand registers driving the logic unit.
   logic [WIDTH-1:0] lu_a_q, lu_a_d;
   logic [WIDTH-1:0] lu_b_q, lu_b_d;
   logic             lu_fn_q, lu_fn_d;
   logic             s1_valid_q, s1_valid_d;

   // Result buffer storage, head pointer and occupancy.
   logic [WIDTH-1:0] buf_data_q [0:1];
   logic [WIDTH-1:0] buf_data_d [0:1];
   logic             buf_zero_q [0:1];
   logic             buf_zero_d [0:1];
   logic             head_q, head_d;
   logic [1:0]       count_q, count_d;

   // Registered result-channel outputs and status.
   logic             res_valid_q, res_valid_d;
   logic [WIDTH-1:0] res_data_q, res_data_d;
   logic             res_zero_q, res_zero_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] ops_count_q, ops_count_d;

   // Handshake qualifiers.
   logic             pop;
   logic             accept;
   logic             tail;
   logic [2:0]       occupancy;

   // res_valid_q always equals (count_q != 0), so it qualifies the pop directly.
   assign pop = res_valid_q && res_ready;

   // Occupancy the buffer will have after this edge if no new command enters:
   // the current entries, plus the stage-1 result about to be captured, minus
   // the entry leaving. A new command is only taken when it still fits after
   // its own capture one cycle later, so capture never meets a full buffer.
   // pop implies count_q >= 1, so the subtraction cannot underflow.
   assign occupancy = {1'b0, count_q} + {2'b00, s1_valid_q} - {2'b00, pop};
   assign cmd_ready = (occupancy < 3'd2);
   assign accept    = cmd_valid && cmd_ready;

   // Tail slot: with two slots, head + count reduces to an XOR of the low bit.
   assign tail = head_q ^ count_q[0];

   // Next-state computation for both stages, buffer and counters.
   always_comb begin
      lu_a_d      = lu_a_q;
      lu_b_d      = lu_b_q;
      lu_fn_d     = lu_fn_q;
      s1_valid_d  = accept;
      buf_data_d  = buf_data_q;
      buf_zero_d  = buf_zero_q;
      head_d      = head_q;
      count_d     = count_q;
      ops_count_d = ops_count_q;

      // Stage 1 load; without an accept the operand ports hold their values.
      if (accept) begin
         lu_a_d  = cmd_a;
         lu_b_d  = cmd_b;
         lu_fn_d = cmd_fn;
      end else begin
         lu_a_d  = lu_a_q;
         lu_b_d  = lu_b_q;
         lu_fn_d = lu_fn_q;
      end

      // Stage 2 capture of the logic unit result into the tail slot.
      if (s1_valid_q) begin
         buf_data_d[tail] = lu_c;
         buf_zero_d[tail] = is_zero(lu_c);
      end else begin
         buf_data_d = buf_data_q;
         buf_zero_d = buf_zero_q;
      end

      // Head advances on every pop, including a simultaneous capture.
      if (pop) begin
         head_d      = ~head_q;
         ops_count_d = ops_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         head_d      = head_q;
         ops_count_d = ops_count_q;
      end

      case ({s1_valid_q, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase

      // Output registers present the head entry as it will stand after the edge.
      res_valid_d = (count_d != 2'd0);
      res_data_d  = buf_data_d[head_d];
      res_zero_d  = buf_zero_d[head_d];
      busy_d      = s1_valid_d || res_valid_d;
   end

   // State registers; reset empties the pipeline and buffer, discarding results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lu_a_q        <= {WIDTH{1'b0}};
         lu_b_q        <= {WIDTH{1'b0}};
         lu_fn_q       <= 1'b0;
         s1_valid_q    <= 1'b0;
         buf_data_q[0] <= {WIDTH{1'b0}};
         buf_data_q[1] <= {WIDTH{1'b0}};
         buf_zero_q[0] <= 1'b1;
         buf_zero_q[1] <= 1'b1;
         head_q        <= 1'b0;
         count_q       <= 2'd0;
         res_valid_q   <= 1'b0;
         res_data_q    <= {WIDTH{1'b0}};
         res_zero_q    <= 1'b1;
         busy_q        <= 1'b0;
         ops_count_q   <= {CNT_W{1'b0}};
      end else begin
         lu_a_q        <= lu_a_d;
         lu_b_q        <= lu_b_d;
         lu_fn_q       <= lu_fn_d;
         s1_valid_q    <= s1_valid_d;
         buf_data_q    <= buf_data_d;
         buf_zero_q    <= buf_zero_d;
         head_q        <= head_d;
         count_q       <= count_d;
         res_valid_q   <= res_valid_d;
         res_data_q    <= res_data_d;
         res_zero_q    <= res_zero_d;
         busy_q        <= busy_d;
         ops_count_q   <= ops_count_d;
      end
   end

   assign lu_a      = lu_a_q;
   assign lu_b      = lu_b_q;
   assign lu_fn     = lu_fn_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_zero  = res_zero_q;
   assign busy      = busy_q;
   assign ops_count = ops_count_q;

endmodule

// File: tb/tb_logic_unit_driver.sv
//------------------------------------------------------------------------------
// tb_logic_unit_driver
//
// Directed bench for logic_unit_driver. A behavioural logic unit closes the
// lu_* loop. Expected results are pushed to a queue at command accept and
// popped/compared when the result channel hands a result over. A second
// instance with CNT_W = 4 shares all inputs and is used for the wrap check.
//------------------------------------------------------------------------------
module tb_logic_unit_driver;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_fn;
   logic          res_ready;
   logic [W-1:0]  cmd_a;
   logic [W-1:0]  cmd_b;

   logic          cmd_ready, lu_fn, res_valid, res_zero, busy;
   logic [W-1:0]  lu_a, lu_b, lu_c, res_data;
   logic [15:0]   ops_count;

   logic          w_cmd_ready, w_lu_fn, w_res_valid, w_res_zero, w_busy;
   logic [W-1:0]  w_lu_a, w_lu_b, w_lu_c, w_res_data;
   logic [3:0]    w_ops_count;

   int            n_cmp = 0;
   int            n_err = 0;
   int            pops  = 0;
   int            nacc  = 0;
   bit            last_acc;
   bit            last_pop;
   logic [W:0]    sb [$];

   always #5 clk = ~clk;

   // Behavioural logic units.
   assign lu_c   = lu_fn   ? (lu_a ^ lu_b)     : (lu_a & lu_b);
   assign w_lu_c = w_lu_fn ? (w_lu_a ^ w_lu_b) : (w_lu_a & w_lu_b);

   logic_unit_driver #(.WIDTH(W), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fn(cmd_fn),
      .lu_a(lu_a), .lu_b(lu_b), .lu_fn(lu_fn), .lu_c(lu_c),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_zero(res_zero),
      .busy(busy), .ops_count(ops_count)
   );

   logic_unit_driver #(.WIDTH(W), .CNT_W(4)) dut_w (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(w_cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fn(cmd_fn),
      .lu_a(w_lu_a), .lu_b(w_lu_b), .lu_fn(w_lu_fn), .lu_c(w_lu_c),
      .res_valid(w_res_valid), .res_ready(res_ready),
      .res_data(w_res_data), .res_zero(w_res_zero),
      .busy(w_busy), .ops_count(w_ops_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called just after a negedge with inputs driven: scores this cycle's
   // handshakes, then advances to the next negedge.
   task automatic cycle();
      logic [W:0] e;
      #1;
      last_pop = res_valid && res_ready;
      last_acc = cmd_valid && cmd_ready;
      if (last_pop) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            check("res_data", res_data, e[W-1:0]);
            check("res_zero", 32'(res_zero), 32'(e[W]));
         end
         pops++;
      end
      if (last_acc) begin
         e[W-1:0] = cmd_fn ? (cmd_a ^ cmd_b) : (cmd_a & cmd_b);
         e[W]     = (e[W-1:0] == 32'd0);
         sb.push_back(e);
         nacc++;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic fn);
      cmd_valid = 1'b1;
      cmd_a     = a;
      cmd_b     = b;
      cmd_fn    = fn;
   endtask

   task automatic drain(input string tag);
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      for (int i = 0; i < 12 && (sb.size() != 0 || busy); i++) cycle();
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      res_ready = 1'b0;
      sb.delete();
      pops = 0;
      nacc = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   logic [W-1:0] bp_a [0:2];
   logic [W-1:0] bp_b [0:2];
   logic         bp_f [0:2];
   logic [4:0]   bp_rdy;
   int           idx;

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_fn = 1'b0; res_ready = 1'b0;
      bp_a[0] = 32'h1111_0000; bp_b[0] = 32'h1F1F_1F1F; bp_f[0] = 1'b0;
      bp_a[1] = 32'hDEAD_BEEF; bp_b[1] = 32'h0000_FFFF; bp_f[1] = 1'b1;
      bp_a[2] = 32'hCAFE_0000; bp_b[2] = 32'hCAFE_0000; bp_f[2] = 1'b1;
      bp_rdy  = 5'b00011;

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_lu_a", lu_a, 32'd0);
      check("rst_lu_b", lu_b, 32'd0);
      check("rst_lu_fn", 32'(lu_fn), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_data", res_data, 32'd0);
      check("rst_res_zero", 32'(res_zero), 32'd1);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ops_count", 32'(ops_count), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // AND with latency checks.
      drive(32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0);
      cycle();
      cmd_valid = 1'b0;
      check("and_accepted", 32'(last_acc), 32'd1);
      check("and_lu_a", lu_a, 32'hFFFF_0000);
      check("and_lu_b", lu_b, 32'h0F0F_0F0F);
      check("and_lu_fn", 32'(lu_fn), 32'd0);
      check("and_early_valid", 32'(res_valid), 32'd0);
      check("and_busy", 32'(busy), 32'd1);
      cycle();
      check("and_res_valid", 32'(res_valid), 32'd1);
      check("and_res_data", res_data, 32'h0F0F_0000);
      check("and_res_zero", 32'(res_zero), 32'd0);
      res_ready = 1'b1;
      cycle();
      check("and_popped_valid", 32'(res_valid), 32'd0);
      check("and_ops_count", 32'(ops_count), 32'd1);

      // XOR and zero flag.
      drive(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
      cycle();
      drive(32'h1234_5678, 32'h1234_5678, 1'b1);
      cycle();
      drain("xor");

      // Backpressure: only two accepted while res_ready is low.
      res_ready = 1'b0;
      idx = 0;
      for (int i = 0; i < 5; i++) begin
         if (idx < 3) drive(bp_a[idx], bp_b[idx], bp_f[idx]);
         else cmd_valid = 1'b0;
         #1;
         check("bp_cmd_ready", 32'(cmd_ready), 32'(bp_rdy[i]));
         cycle();
         if (last_acc) idx++;
      end
      check("bp_accepted", 32'(idx), 32'd2);
      res_ready = 1'b1;
      if (idx < 3) drive(bp_a[idx], bp_b[idx], bp_f[idx]);
      #1;
      check("bp_release_ready", 32'(cmd_ready), 32'd1);
      cycle();
      check("bp_release_acc", 32'(last_acc), 32'd1);
      check("bp_release_pop", 32'(last_pop), 32'd1);
      drain("bp");

      // Streaming: 100 back-to-back random commands.
      apply_reset();
      res_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         drive($urandom, $urandom, 1'($urandom_range(0, 1)));
         #1;
         check("stream_ready", 32'(cmd_ready), 32'd1);
         cycle();
      end
      drain("stream");
      check("stream_ops_count", 32'(ops_count), 32'd100);

      // Reset mid-operation: one buffered, one in stage 1.
      res_ready = 1'b0;
      drive(32'h0BAD_F00D, 32'hFFFF_FFFF, 1'b0);
      cycle();
      drive(32'h7777_7777, 32'h0000_0001, 1'b1);
      cycle();
      cmd_valid = 1'b0;
      check("mid_res_valid_pre", 32'(res_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_res_valid", 32'(res_valid), 32'd0);
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_lu_a", lu_a, 32'd0);
      check("mid_ops_count", 32'(ops_count), 32'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      res_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("post_rst_valid", 32'(res_valid), 32'd0);
         cycle();
      end
      check("post_rst_ops", 32'(ops_count), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);

      // Counter wrap on the CNT_W = 4 instance.
      apply_reset();
      res_ready = 1'b1;
      for (int i = 0; i < 60 && pops < 17; i++) begin
         if (nacc < 17) drive($urandom, $urandom, 1'($urandom_range(0, 1)));
         else cmd_valid = 1'b0;
         cycle();
         if (last_pop && pops == 15) check("wrap_15", 32'(w_ops_count), 32'd15);
         if (last_pop && pops == 16) check("wrap_16", 32'(w_ops_count), 32'd0);
         if (last_pop && pops == 17) check("wrap_17", 32'(w_ops_count), 32'd1);
      end
      check("wrap_pops", 32'(pops), 32'd17);
      check("wrap_wide_count", 32'(ops_count), 32'd17);
      drain("wrap");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
